// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width/depth, programmable almost-full/empty
// thresholds, occupancy count, error pulses and selectable FWFT read mode.
module sync_fifo_param #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = 12,
  parameter  int AE_THRESH = 2,
  parameter  int FWFT      = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_enable,
  output logic [DATA_W-1:0] r_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              rd_ok;
  logic              wr_ok;

  // A full FIFO still accepts a write when the same edge pops a word.
  assign rd_ok = r_enable & ~empty;
  assign wr_ok = w_enable & (~full | rd_ok);

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // NOTE: storage has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wr_ptr] <= w_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= w_enable & ~wr_ok;
      underflow <= r_enable & ~rd_ok;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero when nothing is stored.
      always_comb begin
        r_data = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_registered
      always_ff @(posedge clk) begin
        if (reset)      r_data <= '0;
        else if (rd_ok) r_data <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised successor to the team's 8-bit synchronous FIFO. Single-clock FIFO with configurable data width and depth, and programmable almost-full/almost-empty thresholds. Provides an occupancy count, one-cycle overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Sits between a single-clock producer and consumer as the generic buffering element for datapath blocks.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, need not be a power of two)
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
w_enable  in  1  write request
w_data  in  DATA_W  write data
r_enable  in  1  read (pop) request
r_data  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CW  occupancy, CW = clog2(DEPTH+1)
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset: one clock, synchronous, active-high. Sampled high at a rising edge clears wr_ptr, rd_ptr, count, r_data, overflow, underflow. Afterwards empty=1, almost_empty=1, full=0, almost_full=0. Storage array is not cleared. Reset mid-operation discards all contents; any w_enable/r_enable in the reset cycle is ignored.
- Pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1 (explicit compare, not power-of-two masking).
- Acceptance, evaluated per edge on pre-edge state:
  - rd_ok = r_enable & !empty.
  - wr_ok = w_enable & (!full | rd_ok).
  - A write while full is accepted only if a read is accepted in the same cycle.
  - A read while empty is always rejected, even with a simultaneous write.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Flags are combinational compares of the count register, so they update in the same cycle count changes. No flag is derived from the pointers.
- Error pulses:
  - overflow = 1 for exactly the cycle after an edge where w_enable=1 and wr_ok=0.
  - underflow = 1 likewise for r_enable=1 and rd_ok=0.
  - Both are 0 otherwise. Neither changes FIFO state.
- FWFT=0 read mode:
  - On rd_ok, r_data is loaded with mem[rd_ptr] and is valid the cycle after the read (1-cycle latency).
  - r_data holds its value when no read is accepted.
- FWFT=1 read mode:
  - r_data = mem[rd_ptr] combinationally whenever empty=0; r_enable pops the displayed word.
  - r_data is 0 when empty.
  - A word written into an empty FIFO is visible on r_data the cycle after the write edge.
- Write: on wr_ok, mem[wr_ptr] <= w_data at the edge and wr_ptr advances.

Test Plan:
- Reset and fill (DEPTH=16, FWFT=0): reset 1 cycle, write 0x01..0x10 -> count 1..16; almost_full rises when count reaches 12; full=1 at 16; empty and almost_empty fall after the 1st and 3rd writes respectively.
- Overflow: FIFO full, w_enable=1 with w_data=0xAA, r_enable=0 -> overflow pulses 1 cycle, count stays 16, later reads return 0x01..0x10 and never 0xAA.
- Drain and underflow: read 16 times -> r_data 0x01..0x10, each one cycle after its r_enable; 17th read -> underflow pulse, r_data holds 0x10, empty=1.
- Simultaneous read/write: when full, write 0x55 and read in the same cycle -> both accepted, count stays 16, 0x55 emerges last. When empty, both in the same cycle -> underflow pulse, write accepted, count=1.
- Wrap-around with DEPTH=5: push/pop 13 words interleaved -> pointers wrap, data order preserved, count never above 5.
- FWFT=1: write 0x3C into empty FIFO -> r_data=0x3C next cycle with no r_enable. Assert reset mid-fill at count=7 -> count=0, empty=1, r_data=0 the cycle after.
